// File: rtl/kbd_move_decoder.sv
// PS/2 set-2 scan-code decoder producing held-key levels for the host/guest movement controllers.
// Optional prefix-sequence timeout is compiled in when KBD_TIMEOUT_EN is defined.
module kbd_move_decoder #(
   parameter int unsigned TIMEOUT_CYCLES = 3_250_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       flush,
   output logic       host_left,
   output logic       host_right,
   output logic       host_jump,
   output logic       guest_left,
   output logic       guest_right,
   output logic       guest_jump,
   output logic       game_reset,
   output logic       seq_err
);

   typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

   state_t     state, state_nxt;
   logic [6:0] keys, keys_nxt;
   logic       err_nxt;

   // Counter is 22 bits wide, so the timeout must fit in it.
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 32'd4194304) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1..2**22");
   end

   // Key bit order: {enter, W, D, A, up, right, left}
   function automatic logic [6:0] plain_mask(input logic [7:0] b);
      case (b)
         8'h1C:   plain_mask = 7'b000_1000;
         8'h23:   plain_mask = 7'b001_0000;
         8'h1D:   plain_mask = 7'b010_0000;
         8'h5A:   plain_mask = 7'b100_0000;
         default: plain_mask = '0;
      endcase
   endfunction

   function automatic logic [6:0] ext_mask(input logic [7:0] b);
      case (b)
         8'h6B:   ext_mask = 7'b000_0001;
         8'h74:   ext_mask = 7'b000_0010;
         8'h75:   ext_mask = 7'b000_0100;
         default: ext_mask = '0;
      endcase
   endfunction

`ifdef KBD_TIMEOUT_EN
   localparam logic [21:0] CNT_MAX = 22'(TIMEOUT_CYCLES - 1);
   logic [21:0] cnt, cnt_nxt;
`endif

   always_comb begin
      state_nxt = state;
      keys_nxt  = keys;
      err_nxt   = 1'b0;
      if (flush) begin
         state_nxt = IDLE;
         keys_nxt  = '0;
      end else if (rx_valid) begin
         case (state)
            IDLE: begin
               if (rx_data == 8'hE0)      state_nxt = EXT;
               else if (rx_data == 8'hF0) state_nxt = BRK;
               else                       keys_nxt  = keys | plain_mask(rx_data);
            end
            EXT: begin
               if (rx_data == 8'hF0) state_nxt = EXT_BRK;
               else if (rx_data != 8'hE0) begin
                  keys_nxt  = keys | ext_mask(rx_data);
                  state_nxt = IDLE;
               end
            end
            BRK: begin
               if (rx_data == 8'hE0) begin
                  state_nxt = EXT;
                  err_nxt   = 1'b1;
               end else if (rx_data != 8'hF0) begin
                  keys_nxt  = keys & ~plain_mask(rx_data);
                  state_nxt = IDLE;
               end
            end
            default: begin
               state_nxt = IDLE;
               if (rx_data == 8'hE0 || rx_data == 8'hF0) err_nxt  = 1'b1;
               else                                      keys_nxt = keys & ~ext_mask(rx_data);
            end
         endcase
      end
`ifdef KBD_TIMEOUT_EN
      else if (state != IDLE && cnt == CNT_MAX) begin
         state_nxt = IDLE;
         err_nxt   = 1'b1;
      end
`endif
   end

`ifdef KBD_TIMEOUT_EN
   always_comb begin
      cnt_nxt = cnt;
      if (flush || rx_valid || state == IDLE) cnt_nxt = '0;
      else if (cnt != CNT_MAX)               cnt_nxt = cnt + 22'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt <= '0;
      else     cnt <= cnt_nxt;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         keys    <= '0;
         seq_err <= 1'b0;
      end else begin
         state   <= state_nxt;
         keys    <= keys_nxt;
         seq_err <= err_nxt;
      end
   end

   assign {game_reset, guest_jump, guest_right, guest_left, host_jump, host_right, host_left} = keys;

endmodule
